// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Purpose  : Request/result bundle between the EX-stage sequencer and the ALU.
// Revision : 1.0
// ============================================================================
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [3:0]       aluctrl;
  logic             chooseshift;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, aluctrl, chooseshift, opa, opb, shamt,
    input  busy, done, result, zero, overflow, illegal
  );

  modport slave (
    input  start, aluctrl, chooseshift, opa, opb, shamt,
    output busy, done, result, zero, overflow, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Registered ALU; single-cycle logic/arith, 1-bit/cycle shifter.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_unit_if.slave    bus
);

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SUB = 4'b0110;
  localparam logic [3:0] C_OP_SLL = 4'b0011;
  localparam logic [3:0] C_OP_SRL = 4'b0100;
  localparam logic [3:0] C_OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             left_q,  left_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q,  ovf_d;
  logic             ill_q,  ill_d;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_ill;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;

  // Single-cycle datapath evaluated straight off the request inputs.
  always_comb begin
    w_sum     = bus.opa + bus.opb;
    w_diff    = bus.opa - bus.opb;
    w_slt     = $signed(bus.opa) < $signed(bus.opb);
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (bus.aluctrl)
      C_OP_AND: w_alu_res = bus.opa & bus.opb;
      C_OP_OR:  w_alu_res = bus.opa | bus.opb;
      C_OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (bus.opa[WIDTH-1] == bus.opb[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.opa[WIDTH-1]);
      end
      C_OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (bus.opa[WIDTH-1] != bus.opb[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.opa[WIDTH-1]);
      end
      C_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      default:  w_alu_ill = 1'b1;
    endcase
  end

  assign w_is_shift = (bus.aluctrl == C_OP_SLL) || (bus.aluctrl == C_OP_SRL);
  assign w_amt      = bus.chooseshift ? bus.shamt : bus.opb[SHW-1:0];
  assign w_shifted  = left_q ? (shreg_q << 1) : (shreg_q >> 1);
  // FIN accepts too, which is what lets single-cycle ops issue back-to-back.
  assign w_accept   = bus.start && (state_q != ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;

    if (state_q == ST_SHIFT) begin
      shreg_d = w_shifted;
      cnt_d   = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) begin
        result_d = w_shifted;
        zero_d   = (w_shifted == '0);
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        state_d  = ST_FIN;
      end
    end else if (w_accept) begin
      if (w_is_shift && (w_amt != '0)) begin
        shreg_d = bus.opa;
        cnt_d   = w_amt;
        left_d  = (bus.aluctrl == C_OP_SLL);
        state_d = ST_SHIFT;
      end else if (w_is_shift) begin
        result_d = bus.opa;
        zero_d   = (bus.opa == '0);
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        state_d  = ST_FIN;
      end else begin
        result_d = w_alu_res;
        zero_d   = (w_alu_res == '0);
        ovf_d    = w_alu_ovf;
        ill_d    = w_alu_ill;
        state_d  = ST_FIN;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.illegal  = ill_q;

endmodule
`default_nettype wire
